// File: rtl/counter_pkg.sv
// Shared constants and types for the modulo-(CNT_MAX+1) timebase counter.
package counter_pkg;
  localparam int CNT_W   = 7;
  localparam int CNT_MAX = 100;

  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/counter.sv
// Free-running modulo-(MAX_VAL+1) up-counter used as a timebase/tick source.
// Counts 0..MAX_VAL and wraps to 0; synchronous active-high reset clears it.
// Optional macro COUNTER_WRAP_FLAG_EN adds a registered one-cycle `wrap`
// output that marks the cycle in which cnt returned to 0 from MAX_VAL.
module counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = CNT_W,
  parameter int MAX_VAL = CNT_MAX
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] cnt
`ifdef COUNTER_WRAP_FLAG_EN
  ,
  output logic             wrap
`endif
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

  // The terminal count must be representable in the count register.
  if (MAX_VAL >= (1 << WIDTH)) begin : g_bad_params
    $error("counter: MAX_VAL (%0d) does not fit in WIDTH (%0d) bits", MAX_VAL, WIDTH);
  end

  logic [WIDTH-1:0] cnt_next;
`ifdef COUNTER_WRAP_FLAG_EN
  logic             wrap_next;
`endif

  // Next count: compare before incrementing so the add can never overflow;
  // any value at or above MAX_VAL (including unreachable ones) returns to 0.
  always_comb begin
    cnt_next = '0;
    if (cnt < MAX_C) begin
      cnt_next = cnt + WIDTH'(1);
    end
`ifdef COUNTER_WRAP_FLAG_EN
    wrap_next = (cnt == MAX_C);
`endif
  end

  // State register; reset dominates counting and suppresses the wrap flag.
  always_ff @(posedge clk) begin
`ifdef COUNTER_WRAP_FLAG_EN
    if (rst) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      wrap <= wrap_next;
    end
`else
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
`endif
  end

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for the modulo-101 counter: the driver pushes the expected
// post-edge value from an edge-count reference model, a monitor pops and
// compares on the falling edge.
module tb_counter;
  import counter_pkg::*;

  typedef struct packed {
    cnt_t c;
    logic w;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  cnt_t cnt;
`ifdef COUNTER_WRAP_FLAG_EN
  logic wrap;
`endif

  int checks = 0;
  int errors = 0;

  exp_t sb[$];
  int   n_since_rst = 0;  // rising edges with rst=0 since the last sampled reset

  counter dut (
    .clk (clk),
    .rst (rst),
    .cnt (cnt)
`ifdef COUNTER_WRAP_FLAG_EN
    ,
    .wrap(wrap)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: count is edges-since-reset modulo (MAX+1); wrap marks
  // each completed period that was not ended by reset.
  task automatic model_edge(input logic r);
    exp_t e;
    if (r) n_since_rst = 0;
    else   n_since_rst = n_since_rst + 1;
    e.c = cnt_t'(n_since_rst % (CNT_MAX + 1));
    e.w = !r && (n_since_rst > 0) && (n_since_rst % (CNT_MAX + 1) == 0);
    sb.push_back(e);
  endtask

  // One clock: set rst away from the edge, then record expectation at the edge.
  task automatic step(input logic r);
    @(negedge clk);
    rst = r;
    @(posedge clk);
    model_edge(r);
  endtask

  // One clock with a short reset pulse entirely between edges.
  task automatic glitch_step();
    @(negedge clk);
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    @(posedge clk);
    model_edge(1'b0);
  endtask

  function automatic int model_cnt();
    return n_since_rst % (CNT_MAX + 1);
  endfunction

  // Monitor: the counter presents a new value every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ($isunknown(cnt) || cnt !== e.c || cnt > cnt_t'(CNT_MAX)) begin
          errors++;
          $display("FAIL cnt at %0t: got %0d expected %0d", $time, cnt, e.c);
        end
`ifdef COUNTER_WRAP_FLAG_EN
        checks++;
        if (wrap !== e.w) begin
          errors++;
          $display("FAIL wrap at %0t: got %b expected %b (cnt exp %0d)", $time, wrap, e.w, e.c);
        end
`endif
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    // Power-up, then reset held for two edges.
    step(1'b1);
    step(1'b1);

    // Full period plus one: 1..100, 0, 1.
    for (int i = 0; i < CNT_MAX + 2; i++) step(1'b0);

    // Reset pulses between edges must not disturb the sequence.
    for (int i = 0; i < 5; i++) glitch_step();

    // Reset for two edges when the count reaches 20, then resume.
    while (model_cnt() != 20) step(1'b0);
    step(1'b1);
    step(1'b1);
    for (int i = 0; i < 3; i++) step(1'b0);

    // Reset exactly when the count sits at MAX: next value 0, no wrap flag.
    while (model_cnt() != CNT_MAX) step(1'b0);
    step(1'b1);
    for (int i = 0; i < 3; i++) step(1'b0);

    // Natural wrap again, then a randomized reset pattern over a long run.
    while (model_cnt() != CNT_MAX) step(1'b0);
    for (int i = 0; i < 160; i++) step(($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0);

    // Let the monitor drain the final expectation.
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
